// File: rtl/cfg_frame_pkg.sv
// Shared definitions for the configuration frame writer: header layout,
// magic value and the writer state encoding.
package cfg_frame_pkg;

    localparam logic [7:0] CFG_MAGIC = 8'hFA;

    localparam int MAGIC_MSB = 31;
    localparam int MAGIC_LSB = 24;
    localparam int FRAME_MSB = 20;
    localparam int FRAME_LSB = 16;
    localparam int COL_MSB   = 12;
    localparam int COL_LSB   = 8;

    localparam int FRAME_W = FRAME_MSB - FRAME_LSB + 1;
    localparam int COL_W   = COL_MSB - COL_LSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        HOLD,
        DISCARD
    } cfg_wr_state_t;

    function automatic logic addrInRange(
        input logic [COL_W-1:0]   col,
        input logic [FRAME_W-1:0] frame,
        input int                 numCols,
        input int                 maxFrames
    );
        return (int'(col) < numCols) && (int'(frame) < maxFrames);
    endfunction

endpackage

// File: rtl/cfg_strobe_decoder.sv
// Combinational column/frame to one-hot frame strobe decode.
// An out-of-range address or a low enable yields an all-zero vector.
import cfg_frame_pkg::*;

module cfg_strobe_decoder #(
    parameter int NumberOfCols    = 23,
    parameter int MaxFramesPerCol = 20
) (
    input  logic [COL_W-1:0]                          col,
    input  logic [FRAME_W-1:0]                        frame,
    input  logic                                      enable,
    output logic [NumberOfCols*MaxFramesPerCol-1:0]   strobe
);

    always_comb begin
        strobe = '0;
        for (int c = 0; c < NumberOfCols; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                if (enable && (int'(col) == c) && (int'(frame) == f)) begin
                    strobe[c*MaxFramesPerCol + f] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cfg_frame_writer.sv
// Write side of the fabric configuration frame interface: collects a header
// plus one word per row, then fires one registered one-hot frame strobe.
//
// state   | meaning
// IDLE    | waiting for a header word
// LOAD    | writing row words into FrameData, row 0 first
// SETUP   | one cycle of FrameData setup before the strobe
// STROBE  | addressed strobe bit high for StrobeCycles cycles
// HOLD    | one cycle of FrameData hold, frame counted
// DISCARD | swallowing the rows of a bad-address frame
import cfg_frame_pkg::*;

module cfg_frame_writer #(
    parameter int NumberOfRows    = 7,
    parameter int NumberOfCols    = 23,
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int StrobeCycles    = 2
) (
    input  logic                                      CLK,
    input  logic                                      RESET,
    input  logic [31:0]                               in_data,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      err_clr,
    output logic [NumberOfRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0]   FrameStrobe,
    output logic                                      busy,
    output logic                                      error,
    output logic [15:0]                               frames_written
);

    localparam int RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam int CntW = $clog2(StrobeCycles + 1);
    localparam logic [RowW-1:0] LastRow = RowW'(NumberOfRows - 1);

    cfg_wr_state_t        state;
    logic [RowW-1:0]      rowCnt;
    logic [CntW-1:0]      strobeCnt;
    logic [COL_W-1:0]     colReg;
    logic [FRAME_W-1:0]   frameReg;
    logic                 strobeEn;
    logic [NumberOfCols*MaxFramesPerCol-1:0] strobeVec;

    logic                 accept;
    logic [7:0]           magicField;
    logic [COL_W-1:0]     colField;
    logic [FRAME_W-1:0]   frameField;

    assign accept     = in_valid && in_ready;
    assign magicField = in_data[MAGIC_MSB:MAGIC_LSB];
    assign colField   = in_data[COL_MSB:COL_LSB];
    assign frameField = in_data[FRAME_MSB:FRAME_LSB];

    // Decode one cycle ahead so the registered strobe lines up with STROBE.
    assign strobeEn = (state == SETUP) || ((state == STROBE) && (strobeCnt != '0));

    cfg_strobe_decoder #(
        .NumberOfCols    (NumberOfCols),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_strobeDecoder (
        .col    (colReg),
        .frame  (frameReg),
        .enable (strobeEn),
        .strobe (strobeVec)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= IDLE;
            rowCnt         <= '0;
            strobeCnt      <= '0;
            colReg         <= '0;
            frameReg       <= '0;
            FrameData      <= '0;
            FrameStrobe    <= '0;
            in_ready       <= 1'b1;
            busy           <= 1'b0;
            error          <= 1'b0;
            frames_written <= '0;
        end else begin
            FrameStrobe <= strobeVec;
            // A new error event later in this block overrides the clear.
            if (err_clr) begin
                error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (magicField != CFG_MAGIC) begin
                            error <= 1'b1;
                        end else begin
                            rowCnt <= '0;
                            busy   <= 1'b1;
                            if (addrInRange(colField, frameField, NumberOfCols, MaxFramesPerCol)) begin
                                colReg   <= colField;
                                frameReg <= frameField;
                                state    <= LOAD;
                            end else begin
                                error <= 1'b1;
                                state <= DISCARD;
                            end
                        end
                    end
                end

                LOAD: begin
                    if (accept) begin
                        for (int r = 0; r < NumberOfRows; r++) begin
                            if (rowCnt == RowW'(r)) begin
                                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= in_data;
                            end
                        end
                        if (rowCnt == LastRow) begin
                            state    <= SETUP;
                            in_ready <= 1'b0;
                        end else begin
                            rowCnt <= rowCnt + 1'b1;
                        end
                    end
                end

                DISCARD: begin
                    if (accept) begin
                        if (rowCnt == LastRow) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            rowCnt <= rowCnt + 1'b1;
                        end
                    end
                end

                SETUP: begin
                    strobeCnt <= CntW'(StrobeCycles - 1);
                    state     <= STROBE;
                end

                STROBE: begin
                    if (strobeCnt == '0) begin
                        state <= HOLD;
                    end else begin
                        strobeCnt <= strobeCnt - 1'b1;
                    end
                end

                HOLD: begin
                    frames_written <= frames_written + 16'd1;
                    state          <= IDLE;
                    in_ready       <= 1'b1;
                    busy           <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
